gb_cart_bus_master: RTL and testbench
=====================================

GB_CART_BUS_MASTER -- requirements
Module: gb_cart_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4: address-to-strobe cycles, range 1..255.
REQ-002 SHALL have parameter STROBE_CYC, default 8: strobe-low cycles, range 1..255.
REQ-003 SHALL have parameter HOLD_CYC, default 2: strobe-high to cycle-end cycles, range 1..255.
REQ-004 SHALL have port sys_clock, input, 1 bit: clock for all state.
REQ-005 SHALL have port sys_resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: host request present.
REQ-007 SHALL have port req_ready, output, 1 bit: block accepts a request this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write cycle, 0 = read cycle.
REQ-009 SHALL have port req_addr, input, 16 bits: cartridge address.
REQ-010 SHALL have port req_wdata, input, 8 bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking cycle completion.
REQ-012 SHALL have port rsp_rdata, output, 8 bits: last read data.
REQ-013 SHALL have port Cart_a, output, 16 bits: cartridge address bus.
REQ-014 SHALL have port Cart_d, inout, 8 bits: cartridge data bus.
REQ-015 SHALL have port Cart_nRD, output, 1 bit: read strobe, active-low.
REQ-016 SHALL have port Cart_nWR, output, 1 bit: write strobe, active-low.
REQ-017 SHALL have port Cart_nCS, output, 1 bit: external-RAM select, active-low.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, DONE.
REQ-019 req_ready SHALL be high only in IDLE.
REQ-020 A request SHALL be accepted on a clock edge where req_valid and req_ready are both high; req_addr, req_wdata and req_write SHALL be registered at that edge only, then IDLE->SETUP.
REQ-021 Cart_a SHALL drive the latched address from SETUP entry through HOLD end, and SHALL keep that value in IDLE until the next accept.
REQ-022 Cart_nCS SHALL be low in SETUP, STROBE and HOLD when the latched address is in 0xA000..0xBFFF; otherwise high.
REQ-023 SETUP SHALL last SETUP_CYC cycles, STROBE STROBE_CYC cycles and HOLD HOLD_CYC cycles, counted by one 8-bit down-counter reloaded on each state entry.
REQ-024 In STROBE, Cart_nRD SHALL be low for reads and Cart_nWR SHALL be low for writes; both strobes SHALL be high in all other states.
REQ-025 For writes, Cart_d SHALL drive the latched data from SETUP through HOLD; otherwise Cart_d SHALL be high-Z.
REQ-026 For reads, rsp_rdata SHALL capture Cart_d at the clock edge ending the last STROBE cycle; writes SHALL leave rsp_rdata unchanged.
REQ-027 DONE SHALL last exactly 1 cycle with rsp_valid high, then go to IDLE; rsp_valid SHALL be low in all other states.
REQ-028 Accept-to-rsp_valid latency SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles; the minimum request period SHALL be that value + 1.
REQ-029 req_valid SHALL be ignored while req_ready is low, and request-field changes after acceptance SHALL have no effect.
REQ-030 Every Cart_* output SHALL come directly from a flop (glitch-free), and nRD and nWR SHALL never be low together.

Reset
REQ-031 On sys_resetn low the FSM SHALL go to IDLE asynchronously, including mid-cycle, with Cart_nRD, Cart_nWR, Cart_nCS = 1, Cart_d high-Z, Cart_a = 0x0000, rsp_valid = 0, rsp_rdata = 0x00, counter = 0.
REQ-032 req_ready SHALL be high from the first clock edge after reset release.

Structure
REQ-033 The shared package gb_cart_pkg SHALL hold the FSM state enum, default timing constants (4/8/2) and external-RAM window constants 0xA000/0xBFFF.
REQ-034 The block SHALL be a single module with no sub-module; FSM and counter are small enough to stay inline.

Verification
REQ-035 Read 0x0150, cart model returns 0xCE -> nRD low for exactly 8 cycles, nWR/nCS high, rsp_rdata = 0xCE, rsp_valid pulse 15 cycles after accept.
REQ-036 Write 0x05 to 0x2000 against the cart ROM mapper, then read 0x4000 -> write shows nWR low for 8 cycles with Cart_d = 0x05; mapper Rom_a[22:14] = 0x005 during the read.
REQ-037 Write 0x5A to 0xA010 -> nCS low across SETUP..HOLD, Cart_d = 0x5A from SETUP to HOLD end, then high-Z; rsp_rdata unchanged.
REQ-038 req_valid held high for 3 back-to-back reads -> accepts 16 cycles apart, req_ready low throughout each cycle, fields changed mid-cycle ignored.
REQ-039 sys_resetn pulsed low mid-STROBE of a write -> nWR high and Cart_d high-Z immediately (asynchronously), no rsp_valid, req_ready high after release.
REQ-040 Parameters 1/1/1 -> read completes with rsp_valid 4 cycles after accept, strobe low exactly 1 cycle.

Source files
------------

// File: rtl/gb_cart_pkg.sv
// Shared definitions for the Game Boy cartridge bus master: FSM states,
// default bus timing and the external-RAM address window.
package gb_cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } gb_cart_state_e;

  localparam int unsigned DEF_SETUP_CYC  = 4;
  localparam int unsigned DEF_STROBE_CYC = 8;
  localparam int unsigned DEF_HOLD_CYC   = 2;

  localparam logic [15:0] XRAM_LO = 16'hA000;
  localparam logic [15:0] XRAM_HI = 16'hBFFF;

  function automatic logic in_xram(input logic [15:0] addr);
    return (addr >= XRAM_LO) && (addr <= XRAM_HI);
  endfunction

endpackage

// File: rtl/gb_cart_bus_master.sv
// Host-request to cartridge-bus sequencer: one read or write per request with
// programmable setup / strobe / hold timing; every Cart_* pin comes from a flop.
module gb_cart_bus_master
  import gb_cart_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic           sys_clock,
  input  logic           sys_resetn,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [15:0]    req_addr,
  input  logic [7:0]     req_wdata,
  output logic           rsp_valid,
  output logic [7:0]     rsp_rdata,
  output logic [15:0]    Cart_a,
  inout  wire  [7:0]     Cart_d,
  output logic           Cart_nRD,
  output logic           Cart_nWR,
  output logic           Cart_nCS,
  output gb_cart_state_e dbg_state_o
);

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  gb_cart_state_e state_q;
  logic [7:0]     cnt_q;
  logic           ready_q;
  logic           write_q;
  logic [15:0]    addr_q;
  logic [7:0]     wdata_q;
  logic           d_oe_q;
  logic           nrd_q;
  logic           nwr_q;
  logic           ncs_q;
  logic           rsp_valid_q;
  logic [7:0]     rdata_q;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is a flop that is high only in IDLE,
  // so fields are sampled exactly once and ignored until the next IDLE.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      d_oe_q      <= 1'b0;
      nrd_q       <= 1'b1;
      nwr_q       <= 1'b1;
      ncs_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q <= 1'b0;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            d_oe_q  <= req_write;
            ncs_q   <= !in_xram(req_addr);
            cnt_q   <= SETUP_LOAD;
            state_q <= ST_SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 8'd0) begin
            nrd_q   <= write_q;
            nwr_q   <= !write_q;
            cnt_q   <= STROBE_LOAD;
            state_q <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 8'd0) begin
            nrd_q <= 1'b1;
            nwr_q <= 1'b1;
            // Read data is still valid here: nRD rises on this same edge.
            if (!write_q) rdata_q <= Cart_d;
            cnt_q   <= HOLD_LOAD;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            ncs_q       <= 1'b1;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_DONE: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign Cart_a      = addr_q;
  assign Cart_nRD    = nrd_q;
  assign Cart_nWR    = nwr_q;
  assign Cart_nCS    = ncs_q;
  assign Cart_d      = d_oe_q ? wdata_q : 8'hzz;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Bench for gb_cart_bus_master: MBC-style cartridge model on the bus, a
// memory-map reference model with an expected-data queue, and a 1/1/1 instance.
module tb_gb_cart_bus_master;
  import gb_cart_pkg::*;

  localparam int S = 4;
  localparam int T = 8;
  localparam int H = 2;
  localparam int LAT = S + T + H + 1;

  // clock / reset
  logic sys_clock;
  logic sys_resetn;
  int   cyc;

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  always @(posedge sys_clock) cyc <= cyc + 1;

  // DUT with default timing
  logic        req_valid, req_ready, req_write, rsp_valid;
  logic [15:0] req_addr, cart_a;
  logic [7:0]  req_wdata, rsp_rdata;
  wire  [7:0]  cart_d;
  logic        cart_nrd, cart_nwr, cart_ncs;
  gb_cart_state_e dbg_state;

  gb_cart_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .Cart_a(cart_a), .Cart_d(cart_d), .Cart_nRD(cart_nrd),
    .Cart_nWR(cart_nwr), .Cart_nCS(cart_ncs), .dbg_state_o(dbg_state)
  );

  // DUT with minimum timing
  logic        req2_valid, req2_ready, req2_write, rsp2_valid;
  logic [15:0] req2_addr, cart2_a;
  logic [7:0]  req2_wdata, rsp2_rdata, c2_val;
  wire  [7:0]  cart2_d;
  logic        cart2_nrd, cart2_nwr, cart2_ncs;
  gb_cart_state_e dbg2_state;

  gb_cart_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut2 (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .req_valid(req2_valid), .req_ready(req2_ready), .req_write(req2_write),
    .req_addr(req2_addr), .req_wdata(req2_wdata),
    .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata),
    .Cart_a(cart2_a), .Cart_d(cart2_d), .Cart_nRD(cart2_nrd),
    .Cart_nWR(cart2_nwr), .Cart_nCS(cart2_ncs), .dbg_state_o(dbg2_state)
  );

  assign cart2_d = !cart2_nrd ? c2_val : 8'hzz;

  // cartridge model: ROM with a 5-bit bank register at 0x2000-0x3FFF, 8 KB RAM
  logic [4:0] cart_bank = 5'd1;
  logic [7:0] cart_ram [0:8191] = '{default: 8'h00};
  logic [8:0] last_rom_hi;
  logic       probe_en;
  logic [7:0] probe_val;
  logic       cart_drv_en;
  logic [7:0] cart_drv_val;

  function automatic logic [7:0] rom_byte(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h9F;
  endfunction

  function automatic logic [22:0] rom_addr(input logic [15:0] a, input logic [4:0] bank);
    if (a < 16'h4000) return {9'd0, a[13:0]};
    return {4'd0, bank, a[13:0]};
  endfunction

  function automatic logic [7:0] cart_side_read(input logic [15:0] a);
    if (in_xram(a)) return cart_ram[a[12:0]];
    if (a < 16'h8000) return rom_byte(rom_addr(a, cart_bank));
    return rom_byte({7'd0, a});
  endfunction

  always_comb begin
    cart_drv_en  = 1'b0;
    cart_drv_val = 8'h00;
    if (!cart_nrd) begin
      cart_drv_en  = 1'b1;
      cart_drv_val = cart_side_read(cart_a);
    end else if (probe_en) begin
      cart_drv_en  = 1'b1;
      cart_drv_val = probe_val;
    end
  end

  assign cart_d = cart_drv_en ? cart_drv_val : 8'hzz;

  always @(negedge sys_clock) begin
    if (!cart_nrd) last_rom_hi <= 9'(rom_addr(cart_a, cart_bank) >> 14);
    if (!cart_nwr) begin
      if (cart_a >= 16'h2000 && cart_a <= 16'h3FFF)
        cart_bank <= (cart_d[4:0] == 5'd0) ? 5'd1 : cart_d[4:0];
      else if (in_xram(cart_a))
        cart_ram[cart_a[12:0]] <= cart_d;
    end
  end

  // reference model of the cartridge memory map, driven by request intent
  logic [4:0] ref_bank = 5'd1;
  logic [7:0] ref_ram [0:8191] = '{default: 8'h00};
  logic [7:0] exp_last;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] expected_read(input logic [15:0] a);
    if (a >= 16'hA000 && a <= 16'hBFFF) return ref_ram[a - 16'hA000];
    if (a >= 16'h4000 && a <= 16'h7FFF) return rom_byte(23'(ref_bank) * 23'h4000 + 23'(a - 16'h4000));
    return rom_byte(23'(a));
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [7:0] d);
    if (a >= 16'h2000 && a <= 16'h3FFF) ref_bank = (d % 32 == 0) ? 5'd1 : 5'(d % 32);
    else if (a >= 16'hA000 && a <= 16'hBFFF) ref_ram[a - 16'hA000] = d;
  endtask

  // scoreboard counters and the single checker
  int n_total;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver: call at a negedge; returns at the negedge where rsp_valid is seen
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         input bit keep_valid, output int acc_cyc);
    int  guard, k, pre, strb, post;
    int  a_bad, ready_bad, both_bad, other_bad, ncs_bad, d_bad;
    bit  seen_low;
    logic strobe_n, other_n;
    pre = 0; strb = 0; post = 0; seen_low = 0;
    a_bad = 0; ready_bad = 0; both_bad = 0; other_bad = 0; ncs_bad = 0; d_bad = 0;
    acc_cyc = -1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge sys_clock);
      guard++;
    end
    check("accept_wait", 32'(guard < 40), 32'd1);
    if (guard >= 40) return;
    check("idle_rsp_low", 32'(rsp_valid), 32'd0);
    acc_cyc = cyc;
    if (wr) ref_write(addr, wdata);
    else exp_last = expected_read(addr);
    exp_q.push_back(exp_last);
    @(negedge sys_clock);
    req_valid = keep_valid; req_addr = 16'($urandom); req_wdata = 8'($urandom);
    req_write = 1'($urandom);
    for (k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge sys_clock);
      if (rsp_valid) break;
      if (req_ready) ready_bad++;
      if (cart_a !== addr) a_bad++;
      if (!cart_nrd && !cart_nwr) both_bad++;
      strobe_n = wr ? cart_nwr : cart_nrd;
      other_n  = wr ? cart_nrd : cart_nwr;
      if (!other_n) other_bad++;
      if (cart_ncs !== !in_xram(addr)) ncs_bad++;
      if (wr && cart_d !== wdata) d_bad++;
      if (!strobe_n) begin
        strb++;
        seen_low = 1;
      end else if (seen_low) post++;
      else pre++;
    end
    check("latency", 32'(k), 32'(LAT));
    check("setup_cyc", 32'(pre), 32'(S));
    check("strobe_cyc", 32'(strb), 32'(T));
    check("hold_cyc", 32'(post), 32'(H));
    check("ready_low_busy", 32'(ready_bad), 32'd0);
    check("addr_stable", 32'(a_bad), 32'd0);
    check("strobe_overlap", 32'(both_bad), 32'd0);
    check("wrong_strobe", 32'(other_bad), 32'd0);
    check("ncs_window", 32'(ncs_bad), 32'd0);
    check("wdata_drive", 32'(d_bad), 32'd0);
    check("done_pins", {29'd0, cart_ncs, cart_nrd, cart_nwr}, 32'h7);
    if (exp_q.size() > 0) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, acc2, guard, k, strb, bad2;
    logic [15:0] a2;
    logic        wr;
    logic [15:0] addr;
    n_total = 0; n_bad = 0; cyc = 0;
    exp_last = 8'h00;
    probe_en = 1'b0; probe_val = 8'h00; c2_val = 8'h00;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req2_valid = 1'b0; req2_write = 1'b0; req2_addr = '0; req2_wdata = '0;
    sys_resetn = 1'b0;
    repeat (3) @(negedge sys_clock);

    // reset state
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_cart_a", 32'(cart_a), 32'd0);
    check("rst_pins", {29'd0, cart_ncs, cart_nrd, cart_nwr}, 32'h7);
    probe_val = 8'h3C; probe_en = 1'b1; #1;
    check("rst_cart_d_z", 32'(cart_d), 32'h3C);
    probe_en = 1'b0;
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    @(negedge sys_clock);
    check("ready_after_release", 32'(req_ready), 32'd1);
    check("ready2_after_release", 32'(req2_ready), 32'd1);

    // directed: ROM read at 0x0150
    run_txn(1'b0, 16'h0150, 8'h00, 1'b0, acc0);
    check("read_0150", 32'(rsp_rdata), 32'hCE);
    @(negedge sys_clock);

    // directed: bank select then banked read
    run_txn(1'b1, 16'h2000, 8'h05, 1'b0, acc0);
    @(negedge sys_clock);
    run_txn(1'b0, 16'h4000, 8'h00, 1'b0, acc0);
    check("rom_bank_hi", 32'(last_rom_hi), 32'h005);
    @(negedge sys_clock);

    // directed: external RAM write, bus released afterwards
    run_txn(1'b1, 16'hA010, 8'h5A, 1'b0, acc0);
    probe_val = 8'hC3; probe_en = 1'b1; #1;
    check("cart_d_released", 32'(cart_d), 32'hC3);
    probe_en = 1'b0;
    @(negedge sys_clock);
    run_txn(1'b0, 16'hA010, 8'h00, 1'b0, acc0);
    check("xram_readback", 32'(rsp_rdata), 32'h5A);

    // back-to-back reads with req_valid held
    run_txn(1'b0, 16'h0104, 8'h00, 1'b1, acc0);
    run_txn(1'b0, 16'h4321, 8'h00, 1'b1, acc1);
    run_txn(1'b0, 16'hB0F0, 8'h00, 1'b0, acc2);
    check("b2b_period_1", 32'(acc1 - acc0), 32'(LAT + 1));
    check("b2b_period_2", 32'(acc2 - acc1), 32'(LAT + 1));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin addr = 16'h2000 + 16'($urandom_range(0, 16'h1FFF)); wr = 1'b1; end
        1: begin addr = 16'h4000 + 16'($urandom_range(0, 16'h3FFF)); wr = 1'b0; end
        2: begin addr = 16'hA000 + 16'($urandom_range(0, 16'h1FFF)); wr = 1'($urandom); end
        default: begin addr = 16'($urandom); wr = 1'($urandom); end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        run_txn(wr, addr, 8'($urandom), 1'b1, acc0);
      end else begin
        run_txn(wr, addr, 8'($urandom), 1'b0, acc0);
        repeat ($urandom_range(1, 3)) @(negedge sys_clock);
      end
    end
    req_valid = 1'b0;
    repeat (LAT + 2) @(negedge sys_clock);

    // asynchronous reset in the middle of a write strobe
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h8123; req_wdata = 8'h77;
    guard = 0;
    while (!req_ready && guard < 40) begin
      @(negedge sys_clock);
      guard++;
    end
    @(negedge sys_clock);
    req_valid = 1'b0;
    guard = 0;
    while (cart_nwr && guard < 20) begin
      @(negedge sys_clock);
      guard++;
    end
    check("midwrite_strobe_seen", 32'(cart_nwr), 32'd0);
    @(negedge sys_clock);
    #2 sys_resetn = 1'b0;
    #1;
    check("arst_nwr", 32'(cart_nwr), 32'd1);
    check("arst_pins", {30'd0, cart_ncs, cart_nrd}, 32'h3);
    check("arst_cart_a", 32'(cart_a), 32'd0);
    check("arst_rdata", 32'(rsp_rdata), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    probe_val = 8'hA5; probe_en = 1'b1; #1;
    check("arst_cart_d_z", 32'(cart_d), 32'hA5);
    probe_en = 1'b0;
    exp_last = 8'h00;
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    @(negedge sys_clock);
    check("arst_ready_release", 32'(req_ready), 32'd1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) k++;
      @(negedge sys_clock);
    end
    check("arst_no_rsp", 32'(k), 32'd0);

    // minimum timing instance
    for (int j = 0; j < 3; j++) begin
      c2_val = 8'($urandom);
      a2 = 16'($urandom);
      req2_valid = 1'b1; req2_write = 1'b0; req2_addr = a2; req2_wdata = 8'($urandom);
      guard = 0;
      while (!req2_ready && guard < 20) begin
        @(negedge sys_clock);
        guard++;
      end
      check("d2_accept", 32'(guard < 20), 32'd1);
      @(negedge sys_clock);
      req2_valid = 1'b0; req2_addr = ~a2;
      k = 1; strb = 0; bad2 = 0;
      while (!rsp2_valid && k < 20) begin
        if (!cart2_nrd) strb++;
        if (cart2_a !== a2) bad2++;
        @(negedge sys_clock);
        k++;
      end
      check("d2_latency", 32'(k), 32'd4);
      check("d2_strobe_cyc", 32'(strb), 32'd1);
      check("d2_addr_stable", 32'(bad2), 32'd0);
      check("d2_rdata", 32'(rsp2_rdata), 32'(c2_val));
      @(negedge sys_clock);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
